// File: rtl/mem_stage_pkg.sv
// Shared types and constants for the RV32 memory stage.
package mem_stage_pkg;

    localparam int unsigned REG_ADDR_WIDTH = 5;

    localparam logic [1:0] RESULT_ALU = 2'b00;
    localparam logic [1:0] RESULT_MEM = 2'b01;
    localparam logic [1:0] RESULT_PC4 = 2'b10;

    typedef enum logic [1:0] {
        IDLE = 2'b00,
        REQ  = 2'b01,
        DONE = 2'b10
    } mem_state_e;

    // A store, or a load selected through the result mux.
    function automatic logic is_access(input logic mem_write, input logic [1:0] result_src);
        return mem_write || (result_src == RESULT_MEM);
    endfunction

endpackage

// File: rtl/memory_stage_if.sv
// Registered request/ready data-memory bus between the memory stage and data memory.
interface memory_stage_if #(
    parameter int unsigned ADDR_WIDTH = 32,
    parameter int unsigned DATA_WIDTH = 32
);
    logic                  MemReq;
    logic                  MemWe;
    logic [ADDR_WIDTH-1:0] MemAddr;
    logic [DATA_WIDTH-1:0] MemWData;
    logic                  MemReady;
    logic [DATA_WIDTH-1:0] MemRData;

    modport master (
        output MemReq, MemWe, MemAddr, MemWData,
        input  MemReady, MemRData
    );

    modport slave (
        input  MemReq, MemWe, MemAddr, MemWData,
        output MemReady, MemRData
    );
endinterface

// File: rtl/mem_wb_reg.sv
// M->W pipeline register; loads a bubble (control cleared, data held) while stalled.
module mem_wb_reg
    import mem_stage_pkg::*;
#(
    parameter int unsigned DATA_WIDTH = 32
) (
    input  logic                      clk,
    input  logic                      rst,
    input  logic                      stall,
    input  logic                      reg_write,
    input  logic [1:0]                result_src,
    input  logic [DATA_WIDTH-1:0]     alu_result,
    input  logic [DATA_WIDTH-1:0]     read_data,
    input  logic [REG_ADDR_WIDTH-1:0] rd,
    output logic                      reg_write_q,
    output logic [1:0]                result_src_q,
    output logic [DATA_WIDTH-1:0]     alu_result_q,
    output logic [DATA_WIDTH-1:0]     read_data_q,
    output logic [REG_ADDR_WIDTH-1:0] rd_q
);

    always_ff @(posedge clk) begin
        if (rst) begin
            reg_write_q  <= 1'b0;
            result_src_q <= RESULT_ALU;
            alu_result_q <= '0;
            read_data_q  <= '0;
            rd_q         <= '0;
        end else if (stall) begin
            reg_write_q  <= 1'b0;
            result_src_q <= RESULT_ALU;
            rd_q         <= '0;
        end else begin
            reg_write_q  <= reg_write;
            result_src_q <= result_src;
            alu_result_q <= alu_result;
            read_data_q  <= read_data;
            rd_q         <= rd;
        end
    end

endmodule

// File: rtl/memory_stage.sv
// RV32 memory stage: word loads/stores over a request/ready bus, stalls upstream while busy.
// Optional one-entry store buffer enabled by defining STORE_BUFFER_EN.
module memory_stage
    import mem_stage_pkg::*;
#(
    parameter int unsigned ADDR_WIDTH = 32,
    parameter int unsigned DATA_WIDTH = 32
) (
    input  logic                      clk,
    input  logic                      rst,
    input  logic                      RegWriteM,
    input  logic [1:0]                ResultSrcM,
    input  logic                      MemWriteM,
    input  logic [DATA_WIDTH-1:0]     ALUResultM,
    input  logic [DATA_WIDTH-1:0]     WriteDataM,
    input  logic [REG_ADDR_WIDTH-1:0] RdM,
    memory_stage_if.master            bus,
    output logic                      StallM,
    output logic                      RegWriteW,
    output logic [1:0]                ResultSrcW,
    output logic [DATA_WIDTH-1:0]     ALUResultW,
    output logic [DATA_WIDTH-1:0]     ReadDataW,
    output logic [REG_ADDR_WIDTH-1:0] RdW
);

    mem_state_e            state;
    logic [DATA_WIDTH-1:0] rdata_q;
    logic [DATA_WIDTH-1:0] rdata_w;
    logic                  access;
    logic                  is_store;

    assign is_store = MemWriteM;
    assign access   = is_access(MemWriteM, ResultSrcM);

`ifdef STORE_BUFFER_EN
    logic sb_busy;
    logic sb_accept;

    // A store seen in IDLE with the buffer free retires immediately.
    assign sb_accept = (state == IDLE) && is_store && !sb_busy;
    assign StallM    = ((state == IDLE) && access && !sb_accept) || (state == REQ);
`else
    assign StallM    = ((state == IDLE) && access) || (state == REQ);
`endif

    // Stores and non-load retirements carry zero read data.
    assign rdata_w = ((state == DONE) && !bus.MemWe) ? rdata_q : '0;

    always_ff @(posedge clk) begin
        if (rst) begin
            state        <= IDLE;
            bus.MemReq   <= 1'b0;
            bus.MemWe    <= 1'b0;
            bus.MemAddr  <= '0;
            bus.MemWData <= '0;
            rdata_q      <= '0;
`ifdef STORE_BUFFER_EN
            sb_busy      <= 1'b0;
`endif
        end else begin
            unique case (state)
                IDLE: begin
`ifdef STORE_BUFFER_EN
                    if (sb_busy) begin
                        // Draining the buffered store; every access waits behind it.
                        if (bus.MemReady) begin
                            bus.MemReq <= 1'b0;
                            sb_busy    <= 1'b0;
                        end
                    end else if (access) begin
                        bus.MemReq   <= 1'b1;
                        bus.MemWe    <= is_store;
                        bus.MemAddr  <= ADDR_WIDTH'(ALUResultM);
                        bus.MemWData <= WriteDataM;
                        if (is_store) begin
                            sb_busy <= 1'b1;
                        end else begin
                            state <= REQ;
                        end
                    end
`else
                    if (access) begin
                        bus.MemReq   <= 1'b1;
                        bus.MemWe    <= is_store;
                        bus.MemAddr  <= ADDR_WIDTH'(ALUResultM);
                        bus.MemWData <= WriteDataM;
                        state        <= REQ;
                    end
`endif
                end
                REQ: begin
                    if (bus.MemReady) begin
                        bus.MemReq <= 1'b0;
                        rdata_q    <= bus.MemRData;
                        state      <= DONE;
                    end
                end
                DONE: begin
                    state <= IDLE;
                end
                default: begin
                    state <= IDLE;
                end
            endcase
        end
    end

    mem_wb_reg #(
        .DATA_WIDTH (DATA_WIDTH)
    ) u_mem_wb_reg (
        .clk          (clk),
        .rst          (rst),
        .stall        (StallM),
        .reg_write    (RegWriteM),
        .result_src   (ResultSrcM),
        .alu_result   (ALUResultM),
        .read_data    (rdata_w),
        .rd           (RdM),
        .reg_write_q  (RegWriteW),
        .result_src_q (ResultSrcW),
        .alu_result_q (ALUResultW),
        .read_data_q  (ReadDataW),
        .rd_q         (RdW)
    );

endmodule

// File: tb/tb_memory_stage.sv
// Self-checking bench for memory_stage: program-order reference model plus latency-programmable memory.
module tb_memory_stage;
    import mem_stage_pkg::*;

    typedef struct {
        logic        rw;
        logic [1:0]  rs;
        logic        mw;
        logic [31:0] alu;
        logic [31:0] wd;
        logic [4:0]  rd;
        int          lat;
    } instr_t;

    typedef struct {
        logic        we;
        logic [31:0] addr;
        logic [31:0] wd;
    } req_t;

    logic        clk = 1'b0;
    logic        rst;
    logic        rw_m;
    logic [1:0]  rs_m;
    logic        mw_m;
    logic [31:0] alu_m;
    logic [31:0] wd_m;
    logic [4:0]  rd_m;
    logic        stall_m;
    logic        rw_w;
    logic [1:0]  rs_w;
    logic [31:0] alu_w;
    logic [31:0] rdat_w;
    logic [4:0]  rd_w;

    memory_stage_if #(.ADDR_WIDTH(32), .DATA_WIDTH(32)) bus ();

    memory_stage #(.ADDR_WIDTH(32), .DATA_WIDTH(32)) dut (
        .clk        (clk),
        .rst        (rst),
        .RegWriteM  (rw_m),
        .ResultSrcM (rs_m),
        .MemWriteM  (mw_m),
        .ALUResultM (alu_m),
        .WriteDataM (wd_m),
        .RdM        (rd_m),
        .bus        (bus),
        .StallM     (stall_m),
        .RegWriteW  (rw_w),
        .ResultSrcW (rs_w),
        .ALUResultW (alu_w),
        .ReadDataW  (rdat_w),
        .RdW        (rd_w)
    );

    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;

    instr_t      prog[$];
    int          stall_cnt[$];
    int          lat_q[$];
    req_t        exp_req[$];
    req_t        obs_req[$];
    logic [31:0] ref_mem[logic [31:0]];
    logic [31:0] bus_mem[logic [31:0]];
    int          pc;
    int          wait_cnt;
    bit          exp_valid;
    logic        e_rw;
    logic [1:0]  e_rs;
    logic [31:0] e_alu;
    logic [31:0] e_rdat;
    logic [4:0]  e_rd;

    task automatic drive_nop();
        rw_m = 1'b0; rs_m = RESULT_ALU; mw_m = 1'b0;
        alu_m = '0; wd_m = '0; rd_m = '0;
    endtask

    task automatic do_reset();
        @(negedge clk);
        rst = 1'b1;
        drive_nop();
        bus.MemReady = 1'b0;
        bus.MemRData = '0;
        @(posedge clk);
        #1;
        rst = 1'b0;
        e_rw = 1'b0; e_rs = 2'b00; e_alu = '0; e_rdat = '0; e_rd = '0;
        exp_valid = 1'b1;
        wait_cnt = 0;
        pc = 0;
        lat_q.delete();
        prog.delete();
    endtask

    // One clock: check last W capture, drive M inputs and memory, predict the next W capture.
    task automatic step();
        instr_t cur;
        logic   stall_s;
        int     lat_now;
        @(negedge clk);
        if (exp_valid) begin
            checks++;
            if (rw_w !== e_rw || rs_w !== e_rs || rd_w !== e_rd || alu_w !== e_alu || rdat_w !== e_rdat) begin
                errors++;
                $display("FAIL w_reg pc=%0d got rw=%0b rs=%0d rd=%0d alu=%h rdata=%h want rw=%0b rs=%0d rd=%0d alu=%h rdata=%h",
                         pc, rw_w, rs_w, rd_w, alu_w, rdat_w, e_rw, e_rs, e_rd, e_alu, e_rdat);
            end
        end
        if (pc < prog.size()) cur = prog[pc];
        else cur = '{1'b0, 2'b00, 1'b0, 32'h0, 32'h0, 5'd0, 0};
        rw_m = cur.rw; rs_m = cur.rs; mw_m = cur.mw;
        alu_m = cur.alu; wd_m = cur.wd; rd_m = cur.rd;

        lat_now = (lat_q.size() != 0) ? lat_q[0] : 0;
        if (bus.MemReq === 1'b1) begin
            if (wait_cnt >= lat_now) begin
                bus.MemReady = 1'b1;
                if (bus.MemWe) bus.MemRData = $urandom();
                else if (bus_mem.exists(bus.MemAddr)) bus.MemRData = bus_mem[bus.MemAddr];
                else bus.MemRData = '0;
            end else begin
                bus.MemReady = 1'b0;
                bus.MemRData = $urandom();
            end
        end else begin
            // Noise on the ready line while idle must be ignored.
            bus.MemReady = 1'($urandom_range(0, 1));
            bus.MemRData = $urandom();
        end
        #1;
        stall_s = stall_m;
        if (bus.MemReq === 1'b1 && bus.MemReady === 1'b1) begin
            obs_req.push_back('{bus.MemWe, bus.MemAddr, bus.MemWData});
            if (bus.MemWe) bus_mem[bus.MemAddr] = bus.MemWData;
            if (lat_q.size() != 0) lat_now = lat_q.pop_front();
            wait_cnt = 0;
        end else if (bus.MemReq === 1'b1) begin
            wait_cnt++;
        end

        if (!stall_s) begin
            e_rw = cur.rw; e_rs = cur.rs; e_rd = cur.rd; e_alu = cur.alu;
            if (cur.mw) begin
                e_rdat = '0;
                ref_mem[cur.alu] = cur.wd;
                exp_req.push_back('{1'b1, cur.alu, cur.wd});
            end else if (cur.rs == RESULT_MEM) begin
                e_rdat = ref_mem.exists(cur.alu) ? ref_mem[cur.alu] : 32'h0;
                exp_req.push_back('{1'b0, cur.alu, cur.wd});
            end else begin
                e_rdat = '0;
            end
            if (pc < prog.size()) pc++;
        end else begin
            e_rw = 1'b0; e_rs = RESULT_ALU; e_rd = '0;
            if (pc < prog.size()) stall_cnt[pc]++;
        end
        @(posedge clk);
    endtask

    task automatic run_program(input int budget);
        int n;
        stall_cnt.delete();
        obs_req.delete();
        exp_req.delete();
        foreach (prog[i]) begin
            stall_cnt.push_back(0);
            if (prog[i].mw || prog[i].rs == RESULT_MEM) lat_q.push_back(prog[i].lat);
        end
        pc = 0;
        n = 0;
        while ((pc < prog.size() || lat_q.size() != 0) && n < budget) begin
            step();
            n++;
        end
        repeat (3) step();
        checks++;
        if (n >= budget) begin
            errors++;
            $display("FAIL timeout retired=%0d of %0d after %0d cycles", pc, prog.size(), n);
        end
        checks++;
        if (obs_req.size() != exp_req.size()) begin
            errors++;
            $display("FAIL req_count got %0d want %0d", obs_req.size(), exp_req.size());
        end
        for (int i = 0; i < obs_req.size() && i < exp_req.size(); i++) begin
            checks++;
            if (obs_req[i].we !== exp_req[i].we || obs_req[i].addr !== exp_req[i].addr ||
                (exp_req[i].we && obs_req[i].wd !== exp_req[i].wd)) begin
                errors++;
                $display("FAIL req[%0d] got we=%0b addr=%h wd=%h want we=%0b addr=%h wd=%h", i,
                         obs_req[i].we, obs_req[i].addr, obs_req[i].wd,
                         exp_req[i].we, exp_req[i].addr, exp_req[i].wd);
            end
        end
    endtask

    task automatic test_reset();
        do_reset();
        @(negedge clk);
        checks++;
        if (bus.MemReq !== 1'b0 || bus.MemWe !== 1'b0 || bus.MemAddr !== 32'h0 ||
            bus.MemWData !== 32'h0 || stall_m !== 1'b0) begin
            errors++;
            $display("FAIL reset_bus got req=%0b we=%0b addr=%h wd=%h stall=%0b want all 0",
                     bus.MemReq, bus.MemWe, bus.MemAddr, bus.MemWData, stall_m);
        end
        rw_m = 1'b1; rs_m = RESULT_ALU; mw_m = 1'b0; alu_m = 32'h55AA; wd_m = 32'h1; rd_m = 5'd3;
        @(negedge clk);
        checks++;
        if (rw_w !== 1'b1 || rd_w !== 5'd3 || alu_w !== 32'h55AA) begin
            errors++;
            $display("FAIL pre_reset_alu got rw=%0b rd=%0d alu=%h want 1 3 000055aa", rw_w, rd_w, alu_w);
        end
        rs_m = RESULT_MEM; alu_m = 32'h40; rd_m = 5'd9;
        @(negedge clk);
        @(negedge clk);
        checks++;
        if (bus.MemReq !== 1'b1 || stall_m !== 1'b1) begin
            errors++;
            $display("FAIL pre_reset_req got req=%0b stall=%0b want 1 1", bus.MemReq, stall_m);
        end
        rst = 1'b1;
        drive_nop();
        @(negedge clk);
        rst = 1'b0;
        checks++;
        if (bus.MemReq !== 1'b0 || stall_m !== 1'b0) begin
            errors++;
            $display("FAIL mid_reset_bus got req=%0b stall=%0b want 0 0", bus.MemReq, stall_m);
        end
        checks++;
        if (rw_w !== 1'b0 || rs_w !== 2'b00 || alu_w !== 32'h0 || rdat_w !== 32'h0 || rd_w !== 5'd0) begin
            errors++;
            $display("FAIL mid_reset_w got rw=%0b rs=%0d alu=%h rdata=%h rd=%0d want all 0",
                     rw_w, rs_w, alu_w, rdat_w, rd_w);
        end
        @(negedge clk);
        checks++;
        if (bus.MemReq !== 1'b0) begin
            errors++;
            $display("FAIL reset_discard got req=%0b want 0", bus.MemReq);
        end
    endtask

    task automatic test_alu();
        do_reset();
        prog.push_back('{1'b1, RESULT_ALU, 1'b0, 32'h1234, 32'h0, 5'd5, 0});
        run_program(50);
        checks++;
        if (stall_cnt[0] != 0) begin
            errors++;
            $display("FAIL alu_stall got %0d want 0", stall_cnt[0]);
        end
    endtask

    task automatic test_load();
        do_reset();
        bus_mem[32'h100] = 32'hDEADBEEF;
        ref_mem[32'h100] = 32'hDEADBEEF;
        prog.push_back('{1'b1, RESULT_MEM, 1'b0, 32'h100, 32'h0, 5'd7, 2});
        run_program(50);
        checks++;
        if (stall_cnt[0] != 4) begin
            errors++;
            $display("FAIL load_stall got %0d want 4", stall_cnt[0]);
        end
    endtask

    task automatic test_store();
        int want;
        do_reset();
        prog.push_back('{1'b0, RESULT_ALU, 1'b1, 32'h200, 32'hCAFEF00D, 5'd4, 0});
        run_program(50);
`ifdef STORE_BUFFER_EN
        want = 0;
`else
        want = 2;
`endif
        checks++;
        if (stall_cnt[0] != want) begin
            errors++;
            $display("FAIL store_stall got %0d want %0d", stall_cnt[0], want);
        end
    endtask

    task automatic test_back_to_back();
        int want[2];
        do_reset();
        bus_mem[32'h180] = 32'h0BADF00D;
        ref_mem[32'h180] = 32'h0BADF00D;
        prog.push_back('{1'b1, RESULT_MEM, 1'b0, 32'h180, 32'h0, 5'd11, 0});
        prog.push_back('{1'b0, RESULT_ALU, 1'b1, 32'h184, 32'h13572468, 5'd0, 0});
        run_program(50);
        want[0] = 2;
`ifdef STORE_BUFFER_EN
        want[1] = 0;
`else
        want[1] = 2;
`endif
        for (int i = 0; i < 2; i++) begin
            checks++;
            if (stall_cnt[i] != want[i]) begin
                errors++;
                $display("FAIL b2b_stall[%0d] got %0d want %0d", i, stall_cnt[i], want[i]);
            end
        end
    endtask

    task automatic test_store_then_load();
        int want[2];
        do_reset();
        prog.push_back('{1'b0, RESULT_ALU, 1'b1, 32'h400, 32'h11223344, 5'd0, 3});
        prog.push_back('{1'b1, RESULT_MEM, 1'b0, 32'h400, 32'h0, 5'd12, 0});
        run_program(60);
`ifdef STORE_BUFFER_EN
        want[0] = 0;
        want[1] = 6;
`else
        want[0] = 5;
        want[1] = 2;
`endif
        for (int i = 0; i < 2; i++) begin
            checks++;
            if (stall_cnt[i] != want[i]) begin
                errors++;
                $display("FAIL st_ld_stall[%0d] got %0d want %0d", i, stall_cnt[i], want[i]);
            end
        end
    endtask

    task automatic test_random();
        do_reset();
        for (int i = 0; i < 40; i++) begin
            instr_t t;
            int     kind;
            kind  = $urandom_range(0, 3);
            t.rw  = 1'($urandom_range(0, 1));
            t.rs  = RESULT_ALU;
            t.mw  = 1'b0;
            t.alu = $urandom();
            t.wd  = $urandom();
            t.rd  = 5'($urandom_range(0, 31));
            t.lat = $urandom_range(0, 3);
            case (kind)
                1: t.rs = RESULT_PC4;
                2: begin
                    t.rs  = RESULT_MEM;
                    t.rw  = 1'b1;
                    t.alu = 32'h300 + 32'(4 * $urandom_range(0, 7));
                end
                3: begin
                    t.mw  = 1'b1;
                    t.rw  = 1'b0;
                    t.rs  = 2'($urandom_range(0, 1));
                    t.alu = 32'h300 + 32'(4 * $urandom_range(0, 7));
                end
                default: ;
            endcase
            prog.push_back(t);
        end
        run_program(2000);
        foreach (prog[i]) begin
            int  want;
            bit  acc;
            acc  = prog[i].mw || prog[i].rs == RESULT_MEM;
            want = acc ? (2 + prog[i].lat) : 0;
`ifdef STORE_BUFFER_EN
            if (!acc) begin
`else
            begin
`endif
                checks++;
                if (stall_cnt[i] != want) begin
                    errors++;
                    $display("FAIL rand_stall[%0d] got %0d want %0d", i, stall_cnt[i], want);
                end
            end
        end
    endtask

    initial begin
        #1000000;
        $display("FAIL watchdog simulation did not finish");
        $fatal(1);
    end

    initial begin
        rst = 1'b1;
        exp_valid = 1'b0;
        drive_nop();
        bus.MemReady = 1'b0;
        bus.MemRData = '0;
        test_reset();
        test_alu();
        test_load();
        test_store();
        test_back_to_back();
        test_store_then_load();
        test_random();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
